// File: rtl/vga_pkg.sv
// Shared VGA framebuffer constants and the arbiter state encoding.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_ADDR_W   = 19;
  localparam int VGA_DATA_W   = 8;
  localparam int VGA_LB_AW    = 10;
  localparam int VGA_Y_W      = 9;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BURST = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vga_fb_rd_pipe.sv
// One-stage read-return tracker: steers RAM read data to the scanline buffer
// or to the host port, one cycle after the read was issued.
module vga_fb_rd_pipe
  import vga_pkg::*;
#(
  parameter int DATA_W = VGA_DATA_W,
  parameter int LB_AW  = VGA_LB_AW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue,
  input  logic              issue_host,
  input  logic [LB_AW-1:0]  issue_x,
  input  logic              issue_zero,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic [LB_AW-1:0]  lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata
);

  logic              pend_reg;
  logic              host_reg;
  logic              zero_reg;
  logic [LB_AW-1:0]  x_reg;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] ret_data;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_reg <= 1'b0;
      host_reg <= 1'b0;
      zero_reg <= 1'b0;
      x_reg    <= '0;
      hold_reg <= '0;
    end else begin
      pend_reg <= issue;
      host_reg <= issue_host;
      zero_reg <= issue_zero;
      x_reg    <= issue_x;
      if (host_rvalid) begin
        hold_reg <= ret_data;
      end
    end
  end

  // Out-of-range host reads never touched the RAM, so their data is forced to 0.
  always_comb begin
    ret_data    = zero_reg ? '0 : mem_rdata;
    lb_we       = rst_ni & pend_reg & ~host_reg;
    lb_addr     = lb_we ? x_reg : '0;
    lb_wdata    = lb_we ? mem_rdata : '0;
    host_rvalid = rst_ni & pend_reg & host_reg;
    if (!rst_ni) begin
      host_rdata = '0;
    end else if (host_rvalid) begin
      host_rdata = ret_data;
    end else begin
      host_rdata = hold_reg;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display line bursts into the scanline buffer take
// strict priority; host accesses fill every idle cycle.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int ADDR_W   = VGA_ADDR_W,
  parameter int DATA_W   = VGA_DATA_W,
  parameter int LB_AW    = VGA_LB_AW,
  parameter int Y_W      = VGA_Y_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fetch_line_i,
  input  logic [Y_W-1:0]    fetch_y_i,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_ack_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              lb_we_o,
  output logic [LB_AW-1:0]  lb_addr_o,
  output logic [DATA_W-1:0] lb_wdata_o,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam logic [ADDR_W:0]  FB_WORDS = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
  localparam logic [LB_AW-1:0] X_LAST   = LB_AW'(H_ACTIVE - 1);

  arb_state_t        state_reg, state_next;
  logic [LB_AW-1:0]  x_reg, x_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic              overrun_reg, overrun_next;
  logic [ADDR_W-1:0] y_ext, row_base;
  logic              fetch_ok, host_in_range;
  logic              rd_issue, rd_host, rd_zero;
  logic [LB_AW-1:0]  rd_x;

  assign y_ext = ADDR_W'(fetch_y_i);

  // 640 = 512 + 128, so the default row base needs only two shifts and an add.
  generate
    if (H_ACTIVE == 640) begin : g_base_shift
      assign row_base = (y_ext << 9) + (y_ext << 7);
    end else begin : g_base_mul
      assign row_base = y_ext * ADDR_W'(H_ACTIVE);
    end
  endgenerate

  assign fetch_ok      = fetch_line_i && (int'({1'b0, fetch_y_i}) < V_ACTIVE);
  assign host_in_range = {1'b0, host_addr_i} < FB_WORDS;

  always_comb begin
    state_next   = state_reg;
    x_next       = x_reg;
    base_next    = base_reg;
    overrun_next = overrun_reg;
    host_ack_o   = 1'b0;
    mem_en_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    rd_issue     = 1'b0;
    rd_host      = 1'b0;
    rd_zero      = 1'b0;
    rd_x         = x_reg;
    if (rst_ni) begin
      case (state_reg)
        ARB_IDLE: begin
          if (fetch_ok) begin
            state_next = ARB_BURST;
            base_next  = row_base;
            x_next     = '0;
          end else if (host_req_i) begin
            host_ack_o = 1'b1;
            if (host_in_range) begin
              mem_en_o    = 1'b1;
              mem_we_o    = host_we_i;
              mem_addr_o  = host_addr_i;
              mem_wdata_o = host_wdata_i;
            end
            rd_issue = ~host_we_i;
            rd_host  = 1'b1;
            rd_zero  = ~host_in_range;
          end
        end
        ARB_BURST: begin
          mem_en_o   = 1'b1;
          mem_addr_o = base_reg + ADDR_W'(x_reg);
          rd_issue   = 1'b1;
          if (x_reg == X_LAST) begin
            state_next = ARB_DRAIN;
          end else begin
            x_next = x_reg + LB_AW'(1);
          end
          if (fetch_line_i) begin
            overrun_next = 1'b1;
          end
        end
        ARB_DRAIN: begin
          state_next = ARB_IDLE;
          if (fetch_line_i) begin
            overrun_next = 1'b1;
          end
        end
        default: state_next = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg   <= ARB_IDLE;
      x_reg       <= '0;
      base_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      x_reg       <= x_next;
      base_reg    <= base_next;
      overrun_reg <= overrun_next;
    end
  end

  assign busy_o    = rst_ni && (state_reg != ARB_IDLE);
  assign overrun_o = rst_ni && overrun_reg;

  vga_fb_rd_pipe #(
    .DATA_W (DATA_W),
    .LB_AW  (LB_AW)
  ) u_rd_pipe (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .issue       (rd_issue),
    .issue_host  (rd_host),
    .issue_x     (rd_x),
    .issue_zero  (rd_zero),
    .mem_rdata   (mem_rdata_i),
    .lb_we       (lb_we_o),
    .lb_addr     (lb_addr_o),
    .lb_wdata    (lb_wdata_o),
    .host_rvalid (host_rvalid_o),
    .host_rdata  (host_rdata_o)
  );

endmodule
